// File: rtl/layer_sched_ctrl.sv
// Five-layer CNN sequencer: launches layers in order, steers the
// shared weight/bias read port and inserts a drain gap between owners.
module layer_sched_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CYCLE_CNT_W  = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [4:0]             layer_done,
  output logic [4:0]             layer_start,
  output logic [4:0]             weight_sel,
  output logic [4:0]             bias_sel,
  output logic [2:0]             cur_layer,
  output logic                   busy,
  output logic                   all_done,
  output logic [CYCLE_CNT_W-1:0] total_cycles
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    DRAIN,
    FINISH
  } state_t;

  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

  state_t     state;
  logic [3:0] drain_cnt;
  logic       done_cap;
  logic [4:0] cur_mask;
  logic       cur_done;
  logic [2:0] nxt_layer;

  function automatic logic [4:0] layer_mask(input logic [2:0] l);
    logic [4:0] m;
    case (l)
      3'd1:    m = 5'b00001;
      3'd2:    m = 5'b00010;
      3'd3:    m = 5'b00100;
      3'd4:    m = 5'b01000;
      3'd5:    m = 5'b10000;
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

  // Layer 3 is pooling and never owns the weight/bias port.
  function automatic logic [4:0] sel_code(input logic [2:0] l);
    return (l == 3'd3) ? 5'd0 : {2'b00, l};
  endfunction

  always_comb begin
    cur_mask  = layer_mask(cur_layer);
    cur_done  = |(layer_done & cur_mask);
    nxt_layer = cur_layer + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      drain_cnt    <= '0;
      done_cap     <= 1'b0;
      layer_start  <= '0;
      weight_sel   <= '0;
      bias_sel     <= '0;
      cur_layer    <= '0;
      busy         <= 1'b0;
      all_done     <= 1'b0;
      total_cycles <= '0;
    end else begin
      layer_start <= '0;
      all_done    <= 1'b0;

      if (state == IDLE && start)
        total_cycles <= '0;
      else if (busy && total_cycles != '1)
        total_cycles <= total_cycles + CYCLE_CNT_W'(1);

      if (state != IDLE && abort) begin
        state      <= IDLE;
        drain_cnt  <= '0;
        done_cap   <= 1'b0;
        weight_sel <= '0;
        bias_sel   <= '0;
        cur_layer  <= '0;
        busy       <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state       <= LAUNCH;
              cur_layer   <= 3'd1;
              layer_start <= 5'b00001;
              weight_sel  <= 5'd1;
              bias_sel    <= 5'd1;
              busy        <= 1'b1;
              done_cap    <= 1'b0;
            end
          end
          LAUNCH: begin
            state    <= RUN;
            done_cap <= cur_done;
          end
          RUN: begin
            if (cur_done || done_cap) begin
              done_cap   <= 1'b0;
              weight_sel <= '0;
              bias_sel   <= '0;
              if (cur_layer == 3'd5) begin
                state    <= FINISH;
                all_done <= 1'b1;
              end else begin
                state     <= DRAIN;
                drain_cnt <= DRAIN_LD;
              end
            end
          end
          DRAIN: begin
            if (drain_cnt <= 4'd1) begin
              state       <= LAUNCH;
              drain_cnt   <= '0;
              cur_layer   <= nxt_layer;
              layer_start <= layer_mask(nxt_layer);
              weight_sel  <= sel_code(nxt_layer);
              bias_sel    <= sel_code(nxt_layer);
            end else begin
              drain_cnt <= drain_cnt - 4'd1;
            end
          end
          FINISH: begin
            state     <= IDLE;
            cur_layer <= '0;
            busy      <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_sched_ctrl.sv
// Directed bench for layer_sched_ctrl: full run, ignored inputs,
// abort, async reset and cycle-counter saturation.
module tb_layer_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  layer_done;

  logic [4:0]  ls, ws, bs;
  logic [2:0]  cl;
  logic        bz, ad;
  logic [19:0] tc;

  logic [4:0]  ls_s, ws_s, bs_s;
  logic [2:0]  cl_s;
  logic        bz_s, ad_s;
  logic [3:0]  tc_s;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_sel [19] = '{5'd1, 5'd1, 5'd0, 5'd0, 5'd2, 5'd2, 5'd0,
                               5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd4,
                               5'd0, 5'd0, 5'd5, 5'd5, 5'd0};

  layer_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .layer_done(layer_done), .layer_start(ls), .weight_sel(ws),
    .bias_sel(bs), .cur_layer(cl), .busy(bz), .all_done(ad),
    .total_cycles(tc)
  );

  layer_sched_ctrl #(.CYCLE_CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .layer_done(layer_done), .layer_start(ls_s), .weight_sel(ws_s),
    .bias_sel(bs_s), .cur_layer(cl_s), .busy(bz_s), .all_done(ad_s),
    .total_cycles(tc_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; layer_done = '0;
    #2;
    checks++;
    if ({ls, ws, bs, cl, bz, ad} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outs got %h expected 0", {ls, ws, bs, cl, bz, ad});
    end
    checks++;
    if (tc !== 20'd0) begin
      errors++; $display("FAIL reset_total got %0d expected 0", tc);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bz !== 1'b0 || ls !== 5'd0) begin
      errors++; $display("FAIL reset_idle got busy=%b ls=%b expected 0", bz, ls);
    end
  endtask

  task automatic full_run(input bit restart);
    logic [4:0] es;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 19; c++) begin
      layer_done = (c > 0 && c % 4 == 1) ? 5'(5'd1 << ((c - 1) / 4)) : 5'd0;
      start = restart && (c == 13);
      es = (c % 4 == 0) ? 5'(5'd1 << (c / 4)) : 5'd0;
      checks++;
      if (ws !== exp_sel[c] || bs !== exp_sel[c]) begin
        errors++;
        $display("FAIL run_sel c=%0d got w=%0d b=%0d expected %0d", c, ws, bs, exp_sel[c]);
      end
      checks++;
      if (ls !== es) begin
        errors++; $display("FAIL run_start c=%0d got %b expected %b", c, ls, es);
      end
      checks++;
      if (cl !== 3'(c / 4 + 1)) begin
        errors++; $display("FAIL run_layer c=%0d got %0d expected %0d", c, cl, c / 4 + 1);
      end
      checks++;
      if (bz !== 1'b1 || ad !== (c == 18)) begin
        errors++; $display("FAIL run_flags c=%0d got busy=%b done=%b expected 1,%b", c, bz, ad, c == 18);
      end
      tick();
    end
    layer_done = '0; start = 1'b0;
    checks++;
    if (bz !== 1'b0 || ad !== 1'b0 || cl !== 3'd0 || ws !== 5'd0) begin
      errors++; $display("FAIL run_end got busy=%b done=%b layer=%0d sel=%0d expected 0", bz, ad, cl, ws);
    end
    checks++;
    if (tc !== 20'd19) begin
      errors++; $display("FAIL run_total got %0d expected 19", tc);
    end
    tick();
    checks++;
    if (tc !== 20'd19 || bz !== 1'b0 || ls !== 5'd0) begin
      errors++; $display("FAIL run_hold got tc=%0d busy=%b ls=%b expected 19,0,0", tc, bz, ls);
    end
  endtask

  task automatic test_stray_done();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    layer_done = 5'b00001; tick(); layer_done = '0;
    tick(); tick();
    checks++;
    if (ws !== 5'd2 || ls !== 5'b00010) begin
      errors++; $display("FAIL stray_launch got sel=%0d ls=%b expected 2,00010", ws, ls);
    end
    tick();
    layer_done = 5'b01001; tick(); layer_done = '0;
    checks++;
    if (ws !== 5'd2 || bs !== 5'd2 || cl !== 3'd2 || ls !== 5'd0) begin
      errors++; $display("FAIL stray_hold got sel=%0d/%0d layer=%0d ls=%b expected 2,2,2,0", ws, bs, cl, ls);
    end
    tick();
    checks++;
    if (ws !== 5'd2 || bz !== 1'b1) begin
      errors++; $display("FAIL stray_hold2 got sel=%0d busy=%b expected 2,1", ws, bz);
    end
    layer_done = 5'b00010; tick(); layer_done = '0;
    checks++;
    if (ws !== 5'd0 || cl !== 3'd2 || bz !== 1'b1) begin
      errors++; $display("FAIL stray_drain got sel=%0d layer=%0d busy=%b expected 0,2,1", ws, cl, bz);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (bz !== 1'b0) begin
      errors++; $display("FAIL stray_abort got busy=%b expected 0", bz);
    end
  endtask

  task automatic test_abort();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    layer_done = 5'b00001; tick(); layer_done = '0;
    tick(); tick(); tick();
    layer_done = 5'b00010; abort = 1'b1; tick();
    layer_done = '0; abort = 1'b0;
    checks++;
    if (bz !== 1'b0 || ws !== 5'd0 || cl !== 3'd0 || ad !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b sel=%0d layer=%0d done=%b expected 0", bz, ws, cl, ad);
    end
    checks++;
    if (tc !== 20'd6) begin
      errors++; $display("FAIL abort_total got %0d expected 6", tc);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ls !== 5'd0 || ad !== 1'b0 || bz !== 1'b0) begin
        errors++; $display("FAIL abort_quiet i=%0d got ls=%b done=%b busy=%b expected 0", i, ls, ad, bz);
      end
      tick();
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (bz !== 1'b0 || tc !== 20'd6) begin
      errors++; $display("FAIL abort_idle_noop got busy=%b tc=%0d expected 0,6", bz, tc);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (ls !== 5'b00001 || cl !== 3'd1 || tc !== 20'd0 || ws !== 5'd1) begin
      errors++; $display("FAIL abort_restart got ls=%b layer=%0d tc=%0d sel=%0d expected 00001,1,0,1", ls, cl, tc, ws);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_async_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    layer_done = 5'b00001; tick(); layer_done = '0;
    checks++;
    if (ws !== 5'd0 || bz !== 1'b1) begin
      errors++; $display("FAIL rst_pre got sel=%0d busy=%b expected 0,1", ws, bz);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({ls, ws, bs, cl, bz, ad} !== 20'd0 || tc !== 20'd0) begin
      errors++; $display("FAIL rst_async got %h tc=%0d expected 0", {ls, ws, bs, cl, bz, ad}, tc);
    end
    #1 rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bz !== 1'b0 || ls !== 5'd0 || ws !== 5'd0) begin
        errors++; $display("FAIL rst_stay i=%0d got busy=%b ls=%b sel=%0d expected 0", i, bz, ls, ws);
      end
      tick();
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (ls !== 5'b00001 || bz !== 1'b1) begin
      errors++; $display("FAIL rst_restart got ls=%b busy=%b expected 00001,1", ls, bz);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_saturate();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      checks++;
      if (tc_s !== 4'(c > 15 ? 15 : c) || tc !== 20'(c)) begin
        errors++; $display("FAIL sat_count c=%0d got %0d/%0d expected %0d/%0d", c, tc_s, tc, c > 15 ? 15 : c, c);
      end
      tick();
    end
    checks++;
    if (tc_s !== 4'd15 || ws_s !== 5'd1 || cl_s !== 3'd1) begin
      errors++; $display("FAIL sat_run got tc=%0d sel=%0d layer=%0d expected 15,1,1", tc_s, ws_s, cl_s);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    tick(); tick();
    checks++;
    if (tc_s !== 4'd15 || tc !== 20'd31 || bz_s !== 1'b0) begin
      errors++; $display("FAIL sat_hold got %0d/%0d busy=%b expected 15/31,0", tc_s, tc, bz_s);
    end
  endtask

  initial begin
    test_reset();
    full_run(1'b0);
    test_stray_done();
    full_run(1'b1);
    test_abort();
    test_async_reset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
